switch_sample_loader: RTL and testbench
=======================================

# switch_sample_loader

Upstream input stage of the butterfly datapath. Synchronises the raw board switches, debounces the operator "ready" switch, and on each debounced rising edge captures one signed DW-bit sample into the next slot of an NOPS-entry operand buffer. When the buffer is full it presents the whole operand set to the butterfly core with a valid/ack handshake, then refills. Runs on the slow board clock produced by the clock divider.

## Interface
Parameters:
- DW, 8: sample width (signed, two's complement)
- NOPS, 4: operands per butterfly set; power of two, at least 2
- DEB_CYCLES, 4: consecutive stable cycles needed to accept a ready-switch level change; at least 1

Ports:
- clk  in  1  slow system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- sw_data  in  DW  raw sample switches (asynchronous)
- sw_ready  in  1  raw ready switch (asynchronous, bouncy)
- op_flat  out  NOPS*DW  operand set; slot k is op_flat[k*DW +: DW]
- op_valid  out  1  operand set complete and held stable
- op_ack  in  1  core accepts the set on a clock edge where op_valid=1
- fill_idx  out  $clog2(NOPS)  next slot to be written, for LED display
- sample_echo  out  DW  last captured sample
- dropped  out  1  sticky: a capture arrived while op_valid=1 and was discarded

## Operation
- Input sync: sw_data and sw_ready each pass through two flops (sync1, sync2).
- Debounce: register `stable` holds the accepted ready level. Counter increments while sync2 != stable and clears while they are equal. When it reaches DEB_CYCLES, stable takes sync2 and the counter clears.
- Capture event: the edge on which stable goes 0->1. A falling edge causes no action.
- State FILL (op_valid=0): a capture writes sync2(sw_data) into slot fill_idx, sets sample_echo to the same value, and increments fill_idx. If the write goes to slot NOPS-1: fill_idx wraps to 0, op_valid goes to 1, next state is PRESENT.
- State PRESENT (op_valid=1): op_flat is frozen.
  - op_ack=1: next state is FILL and op_valid goes to 0.
  - A capture with op_ack=0 is discarded, dropped is set to 1, and sample_echo is unchanged.
  - A capture on the same edge as op_ack is not dropped. It is written to slot 0, fill_idx becomes 1, and the state moves to FILL.
- op_ack while op_valid=0 is ignored.
- Slots are never cleared between frames. Only a slot write changes a slot.
- dropped clears only on reset.

## Timing
- Reset values (the edge where rst=1): every op_flat slot=0, op_valid=0, fill_idx=0, sample_echo=0, dropped=0. Also sync flops=0, stable=0, counter=0, state=FILL.
- Reset has priority over every other event, including mid-fill, mid-debounce, and PRESENT with op_ack.
- A switch held high through reset produces exactly one capture after release, once the debounce delay has elapsed.
- Capture latency with debounce: let edge 1 be the first edge that samples sw_ready=1, with the switch stable from then on. The slot write and the stable rise happen on edge 2+DEB_CYCLES.
- Data captured is the sync2(sw_data) value at that edge. sw_data must be steady for at least 2 cycles before that edge.
- The cycle after the 4th capture (NOPS=4), op_valid=1.
- op_valid stays high until the edge where op_ack=1, and reads 0 on the following cycle.
- Maximum capture rate: one per 2*DEB_CYCLES cycles (a full high/low debounce round trip).

## Configuration
- LOADER_DEBOUNCE_EN defined: debounce counter active as described above.
- LOADER_DEBOUNCE_EN undefined: no counter, and DEB_CYCLES is ignored. stable is a plain register of sync2, and a capture is sync2=1 with stable=0. The write happens on edge 3 after the first sampling edge, so every bounce edge produces a capture.

## Test plan
- Clean presses (DEB_CYCLES=4): press with sw_data=0x05, 0xFB, 0x7F, 0x80. Writes occur on edge 6 of each press. After the 4th press, op_valid=1 and op_flat=0x807FFB05, and fill_idx steps 1,2,3,0.
- Bounce: toggle sw_ready 1,0,1,0 on single cycles, then hold high. The toggling causes no capture. Exactly one capture occurs DEB_CYCLES+2 edges after the hold begins. Repeat with LOADER_DEBOUNCE_EN undefined: expect 3 captures.
- Overrun: fill 4 slots and hold op_ack=0, then press with 0x11. dropped=1, op_flat unchanged, sample_echo keeps its previous value. Then pulse op_ack: op_valid=0 next cycle and dropped stays 1.
- Simultaneous: with op_valid=1, time a capture (0x22) on the op_ack edge. Result: op_valid=0, slot 0=0x22, fill_idx=1, dropped=0.
- Reset mid-fill: capture 2 samples, assert rst for one cycle with sw_ready held high. All outputs return to 0. One capture then follows DEB_CYCLES+2 edges after rst deasserts.
- Stray ack: pulse op_ack during FILL with fill_idx=2. No change to state, fill_idx or op_valid.

Source files
------------

// File: rtl/switch_sample_loader.sv
// Switch input stage: synchronises the raw switches, debounces "ready" and packs captured samples into an operand set.
// Optional feature macro LOADER_DEBOUNCE_EN enables the ready-switch debounce counter; undefined, the synchronised level is used directly.
module switch_sample_loader #(
  parameter int DW         = 8,
  parameter int NOPS       = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            sw_data,
  input  logic                     sw_ready,
  output logic [NOPS*DW-1:0]       op_flat,
  output logic                     op_valid,
  input  logic                     op_ack,
  output logic [$clog2(NOPS)-1:0]  fill_idx,
  output logic [DW-1:0]            sample_echo,
  output logic                     dropped
);

  localparam int IW = $clog2(NOPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NOPS - 1);

  if (NOPS < 2 || (NOPS & (NOPS - 1)) != 0) begin : g_bad_nops
    $error("switch_sample_loader: NOPS must be a power of two >= 2");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("switch_sample_loader: DEB_CYCLES must be >= 1");
  end

  typedef enum logic {S_FILL, S_PRESENT} state_e;

  logic [DW-1:0] data_sync1_q, data_sync2_q;
  logic          rdy_sync1_q, rdy_sync2_q;
  logic          stable_q, stable_d;
  logic          capture;
  state_e        state_q, state_d;
  logic [DW-1:0] slot_q [NOPS];
  logic [DW-1:0] slot_d [NOPS];
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] echo_q, echo_d;
  logic          dropped_q, dropped_d;

`ifdef LOADER_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The level is accepted on the edge where the counter would reach DEB_CYCLES.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    stable_d = stable_q;
    cnt_d    = '0;
    if (rdy_sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = rdy_sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign stable_d = rdy_sync2_q;
`endif

  assign capture = stable_d & ~stable_q;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    idx_d     = idx_q;
    echo_d    = echo_q;
    dropped_d = dropped_q;
    case (state_q)
      S_FILL: begin
        if (capture) begin
          slot_d[idx_q] = data_sync2_q;
          echo_d        = data_sync2_q;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_PRESENT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PRESENT: begin
        // A capture on the accepting edge starts the next set instead of being dropped.
        if (op_ack) begin
          state_d = S_FILL;
          if (capture) begin
            slot_d[0] = data_sync2_q;
            echo_d    = data_sync2_q;
            idx_d     = IW'(1);
          end
        end else if (capture) begin
          dropped_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments only in sequential blocks, so every flop samples pre-edge values.
      data_sync1_q <= '0;
      data_sync2_q <= '0;
      rdy_sync1_q  <= 1'b0;
      rdy_sync2_q  <= 1'b0;
      stable_q     <= 1'b0;
      state_q      <= S_FILL;
      idx_q        <= '0;
      echo_q       <= '0;
      dropped_q    <= 1'b0;
      // NOTE: the operand buffer is small and its contents are visible on op_flat, so it is reset like any register.
      for (int k = 0; k < NOPS; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      data_sync1_q <= sw_data;
      data_sync2_q <= data_sync1_q;
      rdy_sync1_q  <= sw_ready;
      rdy_sync2_q  <= rdy_sync1_q;
      stable_q     <= stable_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      echo_q       <= echo_d;
      dropped_q    <= dropped_d;
      slot_q       <= slot_d;
    end
  end

  for (genvar k = 0; k < NOPS; k++) begin : g_flat
    assign op_flat[k*DW +: DW] = slot_q[k];
  end

  assign op_valid    = (state_q == S_PRESENT);
  assign fill_idx    = idx_q;
  assign sample_echo = echo_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_switch_sample_loader.sv
// Scoreboard bench for switch_sample_loader: stimulus pushes expected captures/frames, a negedge monitor pops and compares.
module tb_switch_sample_loader;

  localparam int DW   = 8;
  localparam int NOPS = 4;
  localparam int DEB  = 4;
`ifdef LOADER_DEBOUNCE_EN
  localparam int LAT = DEB + 2;
`else
  localparam int LAT = 3;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [DW-1:0]         sw_data;
  logic                  sw_ready;
  logic [NOPS*DW-1:0]    op_flat;
  logic                  op_valid;
  logic                  op_ack;
  logic [1:0]            fill_idx;
  logic [DW-1:0]         sample_echo;
  logic                  dropped;

  switch_sample_loader #(.DW(DW), .NOPS(NOPS), .DEB_CYCLES(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_data     (sw_data),
    .sw_ready    (sw_ready),
    .op_flat     (op_flat),
    .op_valid    (op_valid),
    .op_ack      (op_ack),
    .fill_idx    (fill_idx),
    .sample_echo (sample_echo),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at_edge;
    logic [1:0] idx;
    logic [7:0] data;
  } cap_t;

  cap_t        cap_q[$];
  logic [31:0] frame_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic rst_seen = 1'b0;

  logic [7:0] m_slots [NOPS];
  int         m_idx;
  bit         m_valid;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_frame();
    return {m_slots[3], m_slots[2], m_slots[1], m_slots[0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NOPS; k++) m_slots[k] = 8'h00;
    m_idx   = 0;
    m_valid = 0;
  endtask

  task automatic model_capture(input logic [7:0] d, input int at);
    cap_t e;
    if (!m_valid) begin
      m_slots[m_idx] = d;
      if (m_idx == NOPS - 1) begin
        m_idx   = 0;
        m_valid = 1;
        frame_q.push_back(m_frame());
      end else begin
        m_idx++;
      end
      e.at_edge = at;
      e.idx     = 2'(m_idx);
      e.data    = d;
      cap_q.push_back(e);
    end
  endtask

  // Monitor: every change of fill_idx outside reset is one accepted capture.
  logic [1:0] prev_idx   = 2'd0;
  logic       prev_valid = 1'b0;
  always @(negedge clk) begin
    cap_t        e;
    logic [31:0] f;
    if (!rst_seen) begin
      if (fill_idx != prev_idx) begin
        if (cap_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_capture: fill_idx %0d -> %0d at edge %0d", prev_idx, fill_idx, cyc);
        end else begin
          e = cap_q.pop_front();
          check("cap_edge", 64'(cyc), 64'(e.at_edge));
          check("cap_idx", 64'(fill_idx), 64'(e.idx));
          check("cap_echo", 64'(sample_echo), 64'(e.data));
        end
      end
      if (op_valid && !prev_valid) begin
        if (frame_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame: op_flat %0h at edge %0d", op_flat, cyc);
        end else begin
          f = frame_q.pop_front();
          check("frame", 64'(op_flat), 64'(f));
        end
      end
    end
    prev_idx   = fill_idx;
    prev_valid = op_valid;
  end

  task automatic press(input logic [7:0] d);
    @(posedge clk); #1;
    sw_data  = d;
    sw_ready = 1'b1;
    model_capture(d, cyc + LAT);
    repeat (LAT + 1) @(posedge clk);
    #1 sw_ready = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 op_ack = 1'b1;
    @(posedge clk); #1 op_ack = 1'b0;
    m_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1; sw_data = '0; sw_ready = 1'b0; op_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_flat", 64'(op_flat), 64'h0);
    check("rst_valid", 64'(op_valid), 64'h0);
    check("rst_idx", 64'(fill_idx), 64'h0);
    check("rst_echo", 64'(sample_echo), 64'h0);
    check("rst_dropped", 64'(dropped), 64'h0);
    rst = 1'b0;

    // Clean presses fill one complete set.
    press(8'h05); press(8'hFB); press(8'h7F); press(8'h80);
    check("full_valid", 64'(op_valid), 64'h1);
    check("full_flat", 64'(op_flat), 64'h807FFB05);
    check("full_idx", 64'(fill_idx), 64'h0);

    // Overrun while the set is presented.
    press(8'h11);
    check("ovr_dropped", 64'(dropped), 64'h1);
    check("ovr_flat", 64'(op_flat), 64'h807FFB05);
    check("ovr_echo", 64'(sample_echo), 64'h80);
    check("ovr_valid", 64'(op_valid), 64'h1);
    pulse_ack();
    check("ack_valid", 64'(op_valid), 64'h0);
    check("ack_dropped", 64'(dropped), 64'h1);

    // Stray ack in FILL changes nothing.
    press(8'hA1); press(8'hA2);
    pulse_ack();
    check("stray_idx", 64'(fill_idx), 64'h2);
    check("stray_valid", 64'(op_valid), 64'h0);
    check("stray_echo", 64'(sample_echo), 64'hA2);
    press(8'hA3); press(8'hA4);
    check("stray_flat", 64'(op_flat), 64'hA4A3A2A1);
    pulse_ack();

    // Reset mid-fill with the ready switch held high.
    press(8'hB1); press(8'hB2);
    @(posedge clk); #1;
    sw_data = 8'h3C; sw_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    c = cyc;
    model_reset();
    check("mrst_flat", 64'(op_flat), 64'h0);
    check("mrst_valid", 64'(op_valid), 64'h0);
    check("mrst_idx", 64'(fill_idx), 64'h0);
    check("mrst_echo", 64'(sample_echo), 64'h0);
    check("mrst_dropped", 64'(dropped), 64'h0);
    model_capture(8'h3C, c + LAT);
    repeat (LAT + 1) @(posedge clk);
    #1 sw_ready = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    press(8'h3D); press(8'h3E); press(8'h3F);
    check("pre_sim_valid", 64'(op_valid), 64'h1);

    // Capture landing on the op_ack edge starts the next set.
    @(posedge clk); #1;
    sw_data = 8'h22; sw_ready = 1'b1;
    c = cyc;
    cap_q.push_back('{c + LAT, 2'd1, 8'h22});
    m_slots[0] = 8'h22; m_idx = 1; m_valid = 0;
    repeat (LAT - 1) @(posedge clk);
    #1 op_ack = 1'b1;
    @(posedge clk); #1 op_ack = 1'b0;
    check("sim_valid", 64'(op_valid), 64'h0);
    check("sim_flat", 64'(op_flat), 64'h3F3E3D22);
    check("sim_idx", 64'(fill_idx), 64'h1);
    check("sim_dropped", 64'(dropped), 64'h0);
    repeat (2) @(posedge clk);
    #1 sw_ready = 1'b0;
    repeat (LAT + 1) @(posedge clk);

    // Bounce: 1,0,1,0 on single cycles, then hold high.
    #1;
    sw_data = 8'h55; sw_ready = 1'b1;
    c = cyc;
`ifdef LOADER_DEBOUNCE_EN
    model_capture(8'h55, c + 4 + LAT);
`else
    model_capture(8'h55, c + 3);
    model_capture(8'h55, c + 5);
    model_capture(8'h55, c + 7);
`endif
    @(posedge clk); #1 sw_ready = 1'b0;
    @(posedge clk); #1 sw_ready = 1'b1;
    @(posedge clk); #1 sw_ready = 1'b0;
    @(posedge clk); #1 sw_ready = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    #1 sw_ready = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
`ifdef LOADER_DEBOUNCE_EN
    check("bounce_idx", 64'(fill_idx), 64'h2);
`else
    check("bounce_idx", 64'(fill_idx), 64'h0);
    check("bounce_flat", 64'(op_flat), 64'h55555522);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("cap_queue_empty", 64'(cap_q.size()), 64'h0);
    check("frame_queue_empty", 64'(frame_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
